// File: rtl/button_conditioner.sv
// Front-panel button conditioner: per-channel 2-FF synchronizer, counter debouncer, press/release pulses.
// Optional auto-repeat of press pulses on masked channels is enabled by defining BUTTON_AUTO_REPEAT_EN.
`timescale 1ns/1ps

module button_conditioner #(
  parameter int NUM_BUTTONS = 5,
  parameter int DB_CYCLES = 2000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = 5'b11000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_db,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  localparam int CW = ($clog2(DB_CYCLES) > 0) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = ($clog2(REPEAT_DELAY) > 0) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [NUM_BUTTONS-1:0] sync_1;
  logic [NUM_BUTTONS-1:0] sync_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    state_t        state;
    logic [CW-1:0] cnt;
    logic          db_q;
    logic          press_q;
    logic          rel_q;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic [RW-1:0] rpt;
`endif

    // Any disagreeing sample during a WAIT state snaps back, so glitches never reach db_q.
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= RELEASED;
        cnt     <= '0;
        db_q    <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt     <= '0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          RELEASED: begin
            if (sync_2[i]) begin
              state <= PRESS_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!sync_2[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state   <= PRESSED;
              cnt     <= '0;
              db_q    <= 1'b1;
              press_q <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
              rpt     <= '0;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!sync_2[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_ONE;
`ifdef BUTTON_AUTO_REPEAT_EN
            end else if (REPEAT_MASK[i]) begin
              if (rpt == RPT_MAX) begin
                press_q <= 1'b1;
                rpt     <= RPT_RELOAD;
              end else begin
                rpt <= rpt + RW'(1);
              end
`endif
            end
          end
          RELEASE_WAIT: begin
            if (sync_2[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_MAX) begin
              state <= RELEASED;
              cnt   <= '0;
              db_q  <= 1'b0;
              rel_q <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
              rpt   <= '0;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_db[i]      = db_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DB_CYCLES=4: expected pulses are queued with their
// cycle numbers as stimulus is issued, and a negedge monitor pops and compares each observed pulse.
`timescale 1ns/1ps

module tb_button_conditioner;

  localparam int NB = 5;

  typedef struct {
    int           cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  button_conditioner #(
    .NUM_BUTTONS(NB),
    .DB_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK(5'b11000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_db(btn_db),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges; a value driven "at cycle N" is applied just after edge N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] value);
    btn_raw = value;
  endtask

  task automatic expect_pulse(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [NB-1:0] exp_db);
    @(negedge clk);
    vectors++;
    if (btn_db !== exp_db) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: btn_db=%b required %b", name, cyc, btn_db, exp_db);
    end
  endtask

  // Monitor: every cycle that shows a pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if ((|(btn_press | btn_release)) === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pulse cycle %0d: press=%b release=%b, required no pulse",
                 cyc, btn_press, btn_release);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.press !== btn_press || e.rel !== btn_release) begin
          miscompares++;
          $display("[TB] FAIL pulse: got cycle %0d press=%b release=%b, required cycle %0d press=%b release=%b",
                   cyc, btn_press, btn_release, e.cyc, e.press, e.rel);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit bounce_pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    exp_t e;

    // Reset with every button already held; outputs must stay 0 while reset is sampled.
    reset = 1'b1;
    applyStimulus(5'b11111);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({btn_db, btn_press, btn_release} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cycle %0d: db=%b press=%b release=%b required all 0",
                 cyc, btn_db, btn_press, btn_release);
      end
    end
    go_to(3);
    reset = 1'b0;
    expect_pulse(9, 5'b11111, 5'b00000);
    go_to(9);
    checkOutput("db_after_reset_press", 5'b11111);
    go_to(10);
    applyStimulus(5'b00000);
    expect_pulse(16, 5'b00000, 5'b11111);
    go_to(15);
    checkOutput("db_before_release_all", 5'b11111);
    go_to(16);
    checkOutput("db_after_release_all", 5'b00000);

    // Clean press and release on bit 0.
    go_to(20);
    applyStimulus(5'b00001);
    expect_pulse(26, 5'b00001, 5'b00000);
    go_to(25);
    checkOutput("db0_before_accept", 5'b00000);
    go_to(26);
    checkOutput("db0_at_accept", 5'b00001);
    go_to(40);
    applyStimulus(5'b00000);
    expect_pulse(46, 5'b00000, 5'b00001);
    go_to(45);
    checkOutput("db0_before_release", 5'b00001);
    go_to(46);
    checkOutput("db0_after_release", 5'b00000);

    // Bouncing press on bit 2; last 0->1 edge at cycle 55.
    for (int k = 0; k < 9; k++) begin
      go_to(50 + k);
      applyStimulus(bounce_pat[k] ? 5'b00100 : 5'b00000);
    end
    expect_pulse(61, 5'b00100, 5'b00000);
    go_to(60);
    checkOutput("db2_during_bounce", 5'b00000);
    go_to(70);
    applyStimulus(5'b00000);
    expect_pulse(76, 5'b00000, 5'b00100);

    // Bit 1 held, then a 2-cycle low glitch that must be ignored.
    go_to(80);
    applyStimulus(5'b00010);
    expect_pulse(86, 5'b00010, 5'b00000);
    go_to(95);
    applyStimulus(5'b00000);
    go_to(97);
    applyStimulus(5'b00010);
    go_to(99);
    checkOutput("db1_during_glitch", 5'b00010);
    go_to(101);
    checkOutput("db1_after_glitch", 5'b00010);
    go_to(110);
    applyStimulus(5'b00000);
    expect_pulse(116, 5'b00000, 5'b00010);

    // Simultaneous press on bits 0 and 4, released before any repeat could fire.
    go_to(120);
    applyStimulus(5'b10001);
    expect_pulse(126, 5'b10001, 5'b00000);
    go_to(126);
    checkOutput("db_simultaneous", 5'b10001);
    go_to(130);
    applyStimulus(5'b00000);
    expect_pulse(136, 5'b00000, 5'b10001);

    // Bit 3 held 30 cycles past its press pulse at 146.
    go_to(140);
    applyStimulus(5'b01000);
    expect_pulse(146, 5'b01000, 5'b00000);
`ifdef BUTTON_AUTO_REPEAT_EN
    for (int t = 156; t <= 177; t += 3) expect_pulse(t, 5'b01000, 5'b00000);
`endif
    go_to(176);
    applyStimulus(5'b00000);
    expect_pulse(182, 5'b00000, 5'b01000);
    go_to(182);
    checkOutput("db3_after_release", 5'b00000);

    // Reset mid-debounce on bit 0: partial count discarded, fresh press after reset drops.
    go_to(190);
    applyStimulus(5'b00001);
    go_to(193);
    reset = 1'b1;
    go_to(194);
    reset = 1'b0;
    expect_pulse(200, 5'b00001, 5'b00000);
    go_to(199);
    checkOutput("db0_reset_mid_debounce", 5'b00000);
    go_to(200);
    checkOutput("db0_after_reset_press", 5'b00001);
    go_to(205);
    applyStimulus(5'b00000);
    expect_pulse(211, 5'b00000, 5'b00001);

    go_to(230);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_pulse: got none, required cycle %0d press=%b release=%b",
               e.cyc, e.press, e.rel);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
